weight_loader: RTL and testbench
================================

# weight_loader

Streaming writer for the weight store. It accepts framed bytes on a valid/ready byte interface and decodes the frame header (tensor select, start address, length). It writes the payload into the selected weight tensor over a write port that mirrors the read port used by `embedding` (`w_sel`/`w_addr`/`w_data`), then checks a trailing checksum. It sits between the host byte link (UART/DMA) and `weight_store`, and is used to load or patch weights without resynthesising BRAM init files.

## Interface
- `SYNC`, 8'hA5, frame sync byte.
- `SEL_W`, 6, tensor select width.
- `ADDR_W`, 16, tensor byte address width.
- `NUM_SEL`, 38, number of valid tensor selects; `sel >= NUM_SEL` is an error.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `in_data_i`  in  8  stream byte.
- `in_valid_i`  in  1  byte valid.
- `in_ready_o`  out  1  byte accepted when `in_valid_i && in_ready_o` at a rising edge.
- `lock_i`  in  1  weight store in use by inference; payload writes are held off.
- `w_we_o`  out  1  write strobe, single cycle per byte.
- `w_sel_o`  out  SEL_W  tensor select for the write.
- `w_addr_o`  out  ADDR_W  byte address within the tensor.
- `w_data_o`  out  8  write byte.
- `busy_o`  out  1  frame in progress (any state but IDLE).
- `done_o`  out  1  one-cycle pulse: frame ended with a good checksum.
- `err_o`  out  1  one-cycle pulse: frame ended with an error.
- `err_code_o`  out  2  0 none, 1 checksum, 2 bad select, 3 zero length; holds until the next frame end.
- `frame_cnt_o`  out  16  good-frame counter, wraps at 16'hFFFF to 0.

## Operation
- Frame layout: SYNC, SEL, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, LEN payload bytes, CSUM.
- Checksum rule: the 8-bit sum of SEL through CSUM, inclusive, equals 8'h00. SYNC is excluded.
- States: IDLE → SEL → AHI → ALO → LHI → LLO → DATA → CSUM → IDLE.
- IDLE: discards every byte that is not SYNC. On SYNC, go to SEL and clear the running sum.
- SEL: the byte's low SEL_W bits become the select. The upper bits must be 0; otherwise the bad-select flag is set.
- LLO: LEN == 0 sets err_code 3 and skips DATA. The CSUM byte is still consumed and its check is still computed, but err_code 3 takes precedence.
- DATA, per accepted byte: issue a write at the current address, increment the address modulo 2^ADDR_W (wraps, no error), and decrement the remaining count. Leave DATA after the last byte.
- Bad select (sel ≥ NUM_SEL or upper bits set): the payload is consumed, but `w_we_o` never asserts for the frame. At frame end, err_code 2 takes precedence over checksum.
- CSUM: compare the sum.
  - Zero with no other flag: `done_o`, increment `frame_cnt_o`, err_code 0.
  - Otherwise: `err_o`.
- Writes already committed are not rolled back.
- `lock_i`: in DATA, `in_ready_o` = !`lock_i`, so no byte is accepted and no write is issued while locked. In all other states `in_ready_o` = 1 and headers proceed under lock.
- There is no timeout; a truncated frame waits indefinitely. Only reset recovers it.

## Timing
- Reset (async assert, sync release) sets all outputs to 0, the state to IDLE, and `frame_cnt_o` to 0.
- `in_ready_o` is 0 while `rst_ni` is low and 1 from the first edge after release.
- Write latency: the payload byte accepted at edge N drives `w_we_o`/`w_sel_o`/`w_addr_o`/`w_data_o`, registered, during cycle N+1. `w_we_o` is high for exactly one cycle.
- Write-side outputs hold their last value when `w_we_o` = 0.
- Back-to-back valid bytes are accepted every cycle (throughput 1 byte/clk), giving consecutive write strobes.
- `done_o`/`err_o` pulse in the cycle after the CSUM byte is accepted. The state is IDLE in that same cycle, so a SYNC arriving then is accepted.
- Reset mid-frame: the frame is abandoned with no pulse, and any pending write strobe is cleared immediately (async).
- `lock_i` rising in the same cycle a DATA byte is presented: the byte is not accepted, because ready is combinational on `lock_i`.

## Structure
- The shared package `weight_pkg` holds:
  - the frame-state enum,
  - the err_code constants,
  - `SYNC`,
  - `NUM_SEL`,
  - the tensor-select constants (0 = tok_emb, 1 = pos_emb, …), which `embedding` and `weight_store` share.
- One sub-module is natural: `frame_checksum` (running 8-bit sum with clear, accumulate and `is_zero`).

## Test plan
- Good frame: sel=1, addr=16'h0010, len=3, data 11 22 33, correct CSUM → three consecutive `w_we_o` cycles at addr 0x10/0x11/0x12 with data 11/22/33 on sel 1; `done_o` pulses once; `frame_cnt_o`=1.
- Bad checksum: the same frame with CSUM+1 → the writes still occur; `err_o` pulses; `err_code_o`=1; `frame_cnt_o` unchanged.
- Bad select: sel=8'h3F (≥38), len=2 → no `w_we_o` at all; all bytes are consumed; `err_code_o`=2.
- Wrap and garbage: 00 FF ahead of SYNC, then sel=0, addr=16'hFFFF, len=2 → the leading bytes are ignored; writes go to 0xFFFF then 0x0000; `done_o`.
- Lock: hold `lock_i`=1 for 10 cycles mid-DATA with valid high → `in_ready_o`=0 and no writes during the lock; the remaining bytes write correctly after release.
- Reset mid-DATA: pull `rst_ni` low after 1 of 4 payload bytes, then send a new good frame → no pulse for the first frame; the second completes with `frame_cnt_o`=1.

Source files
------------

// File: rtl/weight_pkg.sv
// Shared definitions for the weight store path: frame decoder states, error codes,
// frame constants and the tensor-select map used by embedding and weight_store.
package weight_pkg;
  localparam int SEL_W   = 6;
  localparam int ADDR_W  = 16;
  localparam int NUM_SEL = 38;

  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEL, ST_AHI, ST_ALO, ST_LHI, ST_LLO, ST_DATA, ST_CSUM
  } frame_state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_SEL  = 2'd2;
  localparam logic [1:0] ERR_LEN  = 2'd3;

  // Per-layer tensors are numbered upward from SEL_LAYER_BASE.
  localparam logic [SEL_W-1:0] SEL_TOK_EMB    = 6'd0;
  localparam logic [SEL_W-1:0] SEL_POS_EMB    = 6'd1;
  localparam logic [SEL_W-1:0] SEL_LAYER_BASE = 6'd2;

  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_req_t;

  function automatic logic sel_ok(input logic [7:0] b);
    return (b[7:SEL_W] == '0) && ({2'b00, b[SEL_W-1:0]} < 8'(NUM_SEL));
  endfunction
endpackage

// File: rtl/frame_checksum.sv
// Running 8-bit frame sum. is_zero_o reports whether the sum including the byte
// currently on data_i would be zero, so the check lands on the CSUM accept edge.
module frame_checksum
  import weight_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       acc_i,
  input  logic [7:0] data_i,
  output logic [7:0] sum_o,
  output logic       is_zero_o
);
  logic [7:0] sum_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    sum_q <= '0;
    else if (clr_i) sum_q <= '0;
    else if (acc_i) sum_q <= sum_q + data_i;
  end

  assign sum_o     = sum_q;
  assign is_zero_o = (8'(sum_q + data_i) == 8'h00);
endmodule

// File: rtl/weight_loader.sv
// Framed byte-stream writer for the weight store: decodes SYNC/SEL/ADDR/LEN headers,
// streams payload bytes out as single-cycle writes and validates a trailing checksum.
module weight_loader
  import weight_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              lock_i,
  output logic              w_we_o,
  output logic [SEL_W-1:0]  w_sel_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [7:0]        w_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [15:0]       frame_cnt_o
);
  frame_state_e      state_q, state_d;
  logic              rdy_q;
  logic              accept;
  logic [SEL_W-1:0]  sel_q;
  logic              bad_q, zlen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_hi_q;
  logic [15:0]       rem_q;
  wr_req_t           wr_q;
  logic              done_q, err_q;
  logic [1:0]        code_q;
  logic [15:0]       cnt_q;
  logic [7:0]        sum;
  logic              sum_zero;

  // rdy_q keeps ready low through reset and for the release edge itself.
  assign in_ready_o = rdy_q && !((state_q == ST_DATA) && lock_i);
  assign accept     = in_valid_i && in_ready_o;

  frame_checksum u_csum (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (accept && (state_q == ST_IDLE) && (in_data_i == SYNC)),
    .acc_i     (accept && (state_q != ST_IDLE)),
    .data_i    (in_data_i),
    .sum_o     (sum),
    .is_zero_o (sum_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        ST_IDLE: if (in_data_i == SYNC) state_d = ST_SEL;
        ST_SEL:  state_d = ST_AHI;
        ST_AHI:  state_d = ST_ALO;
        ST_ALO:  state_d = ST_LHI;
        ST_LHI:  state_d = ST_LLO;
        ST_LLO:  state_d = ({len_hi_q, in_data_i} == 16'd0) ? ST_CSUM : ST_DATA;
        ST_DATA: if (rem_q == 16'd1) state_d = ST_CSUM;
        ST_CSUM: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_q    <= 1'b0;
      sel_q    <= '0;
      bad_q    <= 1'b0;
      zlen_q   <= 1'b0;
      addr_q   <= '0;
      len_hi_q <= '0;
      rem_q    <= '0;
      wr_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
      cnt_q    <= '0;
    end else begin
      rdy_q   <= 1'b1;
      wr_q.we <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (accept) begin
        unique case (state_q)
          ST_IDLE: if (in_data_i == SYNC) begin
            bad_q  <= 1'b0;
            zlen_q <= 1'b0;
          end
          ST_SEL: begin
            sel_q <= in_data_i[SEL_W-1:0];
            bad_q <= !sel_ok(in_data_i);
          end
          ST_AHI: addr_q[15:8] <= in_data_i;
          ST_ALO: addr_q[7:0]  <= in_data_i;
          ST_LHI: len_hi_q     <= in_data_i;
          ST_LLO: begin
            rem_q  <= {len_hi_q, in_data_i};
            zlen_q <= ({len_hi_q, in_data_i} == 16'd0);
          end
          ST_DATA: begin
            // A bad select still walks the payload so the stream stays framed.
            if (!bad_q) wr_q <= '{we: 1'b1, sel: sel_q, addr: addr_q, data: in_data_i};
            addr_q <= addr_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
          end
          ST_CSUM: begin
            if (zlen_q) begin
              code_q <= ERR_LEN;
              err_q  <= 1'b1;
            end else if (bad_q) begin
              code_q <= ERR_SEL;
              err_q  <= 1'b1;
            end else if (!sum_zero) begin
              code_q <= ERR_CSUM;
              err_q  <= 1'b1;
            end else begin
              code_q <= ERR_NONE;
              done_q <= 1'b1;
              cnt_q  <= cnt_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign w_we_o      = wr_q.we;
  assign w_sel_o     = wr_q.sel;
  assign w_addr_o    = wr_q.addr;
  assign w_data_o    = wr_q.data;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_code_o  = code_q;
  assign frame_cnt_o = cnt_q;
endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: frames are driven byte by byte, expected writes go
// into a scoreboard queue and are popped by a monitor as write strobes appear.
module tb_weight_loader;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        lock_i;
  logic        w_we_o;
  logic [5:0]  w_sel_o;
  logic [15:0] w_addr_o;
  logic [7:0]  w_data_o;
  logic        busy_o, done_o, err_o;
  logic [1:0]  err_code_o;
  logic [15:0] frame_cnt_o;

  always #5 clk_i = ~clk_i;

  weight_loader dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .lock_i(lock_i), .w_we_o(w_we_o), .w_sel_o(w_sel_o),
    .w_addr_o(w_addr_o), .w_data_o(w_data_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .err_code_o(err_code_o), .frame_cnt_o(frame_cnt_o)
  );

  typedef struct {
    logic [5:0]  sel;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          n_err = 0;
  int          exp_done = 0;
  int          exp_err = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [7:0]  pay [0:7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected write.
  always @(negedge clk_i) begin : mon
    exp_t e;
    if (rst_ni) begin
      if (done_o) n_done++;
      if (err_o)  n_err++;
      if (w_we_o) begin
        chk("wr_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_sel",  {26'd0, w_sel_o},  {26'd0, e.sel});
          chk("wr_addr", {16'd0, w_addr_o}, {16'd0, e.addr});
          chk("wr_data", {24'd0, w_data_o}, {24'd0, e.data});
        end
      end
    end
  end

  // Called and returns at a falling edge; the byte is accepted on the rising edge between.
  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    in_data_i  = b;
    in_valid_i = 1'b1;
    #1;
    while (!in_ready_o && w < 200) begin
      @(negedge clk_i);
      #1;
      w++;
    end
    if (w >= 200) chk("ready_timeout", {31'd0, in_ready_o}, 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // brk >= 0 interrupts the payload after brk bytes with a lock window or a reset.
  task automatic send_frame(input logic [7:0] sel, input logic [15:0] addr, input int len,
                            input logic [7:0] adj, input int brk, input bit do_rst);
    logic [7:0]  hdr [0:4];
    logic [7:0]  sum;
    logic [1:0]  code;
    logic [15:0] a;
    hdr[0] = sel;  hdr[1] = addr[15:8]; hdr[2] = addr[7:0];
    hdr[3] = 8'(len >> 8); hdr[4] = 8'(len);
    sum = 8'h00;
    a = addr;
    send_byte(8'hA5);
    for (int i = 0; i < 5; i++) begin
      sum = sum + hdr[i];
      send_byte(hdr[i]);
    end
    for (int i = 0; i < len; i++) begin
      if (i == brk && do_rst) begin
        #2;
        rst_ni = 1'b0;
        in_valid_i = 1'b0;
        #1;
        chk("rst_we_clear", {31'd0, w_we_o}, 32'd0);
        chk("rst_ready_low", {31'd0, in_ready_o}, 32'd0);
        chk("rst_pulses", {30'd0, done_o, err_o}, 32'd0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        exp_cnt = 16'd0;
        @(negedge clk_i);
        chk("rst_ready_up", {31'd0, in_ready_o}, 32'd1);
        chk("rst_cnt", {16'd0, frame_cnt_o}, 32'd0);
        return;
      end
      if (i == brk) begin
        in_data_i = pay[i];
        in_valid_i = 1'b1;
        lock_i = 1'b1;
        // First falling edge still shows the strobe of the last pre-lock byte.
        @(negedge clk_i);
        for (int c = 0; c < 10; c++) begin
          chk("lock_ready", {31'd0, in_ready_o}, 32'd0);
          chk("lock_no_we", {31'd0, w_we_o}, 32'd0);
          @(negedge clk_i);
        end
        lock_i = 1'b0;
      end
      if (sel < 8'd38) exp_q.push_back('{sel: sel[5:0], addr: a, data: pay[i]});
      a = a + 16'd1;
      sum = sum + pay[i];
      send_byte(pay[i]);
    end
    send_byte(8'h00 - sum + adj);
    in_valid_i = 1'b0;
    code = (len == 0) ? 2'd3 : (sel >= 8'd38) ? 2'd2 : (adj != 8'h00) ? 2'd1 : 2'd0;
    if (code == 2'd0) begin
      exp_cnt = exp_cnt + 16'd1;
      exp_done++;
    end else begin
      exp_err++;
    end
    chk("done_pulse", {31'd0, done_o}, {31'd0, code == 2'd0});
    chk("err_pulse",  {31'd0, err_o},  {31'd0, code != 2'd0});
    chk("err_code",   {30'd0, err_code_o}, {30'd0, code});
    chk("frame_cnt",  {16'd0, frame_cnt_o}, {16'd0, exp_cnt});
    chk("idle_after", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0;
    in_valid_i = 1'b0;
    in_data_i = 8'h00;
    lock_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", {31'd0, in_ready_o}, 32'd0);
    chk("rst_outs", {28'd0, w_we_o, busy_o, done_o, err_o}, 32'd0);
    chk("rst_code", {30'd0, err_code_o}, 32'd0);
    chk("rst_cnt0", {16'd0, frame_cnt_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("ready_after_rst", {31'd0, in_ready_o}, 32'd1);

    // Good frame, then the same frame with a corrupted checksum back to back.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_frame(8'h01, 16'h0010, 3, 8'h00, -1, 1'b0);
    send_frame(8'h01, 16'h0010, 3, 8'h01, -1, 1'b0);

    pay[0] = 8'hAA; pay[1] = 8'hBB;
    send_frame(8'h3F, 16'h0000, 2, 8'h00, -1, 1'b0);

    // Leading garbage, then an address that wraps.
    send_byte(8'h00);
    send_byte(8'hFF);
    in_valid_i = 1'b0;
    chk("garbage_idle", {31'd0, busy_o}, 32'd0);
    pay[0] = 8'h5A; pay[1] = 8'hC3;
    send_frame(8'h00, 16'hFFFF, 2, 8'h00, -1, 1'b0);

    send_frame(8'h01, 16'h0040, 0, 8'h00, -1, 1'b0);

    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
    send_frame(8'h02, 16'h0100, 4, 8'h00, 2, 1'b0);

    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
    send_frame(8'h03, 16'h0020, 4, 8'h00, 1, 1'b1);
    pay[0] = 8'h77; pay[1] = 8'h88;
    send_frame(8'h04, 16'h0000, 2, 8'h00, -1, 1'b0);

    repeat (3) @(negedge clk_i);
    chk("sb_empty", exp_q.size(), 32'd0);
    chk("done_count", n_done, exp_done);
    chk("err_count", n_err, exp_err);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
